// File: rtl/handshake_tx_fifo_pkg.sv
// rtl/handshake_tx_fifo_pkg.sv - shared encodings for the handshake transmit front-end
package handshake_tx_fifo_pkg;

  localparam int HS_MODE_4PH = 0;
  localparam int HS_MODE_2PH = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_WAIT_ACK = 3'b010,
    ST_WAIT_REL = 3'b100
  } hs_state_t;

endpackage

// File: rtl/handshake_tx_fifo_if.sv
// rtl/handshake_tx_fifo_if.sv - push side and receiver side signals of the transmit front-end
interface handshake_tx_fifo_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic          req_i;
  logic [DW-1:0] req_data_i;
  logic          ready_o;
  logic          idle_o;
  logic [LW-1:0] level_o;
  logic          ovf_o;
  logic          done_o;
  logic          ack_i;
  logic          req_o;
  logic [DW-1:0] req_data_o;

  modport master (
    output req_i, req_data_i, ack_i,
    input  ready_o, idle_o, level_o, ovf_o, done_o, req_o, req_data_o
  );

  modport slave (
    input  req_i, req_data_i, ack_i,
    output ready_o, idle_o, level_o, ovf_o, done_o, req_o, req_data_o
  );

endinterface

// File: rtl/handshake_tx_fifo_sync_fifo.sv
// rtl/handshake_tx_fifo_sync_fifo.sv - single-clock FIFO; head word visible combinationally
module hs_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/handshake_tx_fifo.sv
// rtl/handshake_tx_fifo.sv - buffered four-phase / two-phase request transmitter
module handshake_tx_fifo
  import handshake_tx_fifo_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  handshake_tx_fifo_if.slave  bus
);

  localparam int LW = $clog2(DEPTH + 1);

  logic                   full;
  logic                   empty;
  logic                   pop;
  logic [DW-1:0]          head;
  logic [LW-1:0]          level;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  hs_state_t              state;
  logic                   req_q;
  logic [DW-1:0]          data_q;
  logic                   done_q;

  assign pop = (state == ST_IDLE) && !empty;

  hs_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.req_i),
    .push_data (bus.req_data_i),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_i};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_q  <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            data_q <= head;
            req_q  <= (MODE == HS_MODE_2PH) ? ~req_q : 1'b1;
            state  <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (MODE == HS_MODE_2PH) begin
            // toggle handshake completes once ack mirrors the current request phase
            if (ack_s == req_q) begin
              done_q <= 1'b1;
              state  <= ST_IDLE;
            end
          end else if (ack_s) begin
            req_q <= 1'b0;
            state <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (!ack_s) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o    = !full;
  assign bus.ovf_o      = bus.req_i && full;
  assign bus.idle_o     = empty && (state == ST_IDLE);
  assign bus.level_o    = level;
  assign bus.done_o     = done_q;
  assign bus.req_o      = req_q;
  assign bus.req_data_o = data_q;

endmodule

// File: tb/tb_handshake_tx_fifo.sv
// tb/tb_handshake_tx_fifo.sv - directed vector bench for handshake_tx_fifo
module tb_handshake_tx_fifo;

  typedef struct {
    logic        req;
    logic [31:0] data;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_data;
    logic        exp_ready;
    logic        exp_idle;
    logic [2:0]  exp_level;
    logic        exp_done;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 22;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic        man_ack0;
  logic        resp_en0;
  logic        man_ack3;
  logic [2:0]  hist0;
  logic [2:0]  hist1;
  logic        prev0;
  logic        prev1;
  int          done_cnt0;
  int          done_cnt1;
  logic [31:0] cap0[$];
  logic [31:0] cap1[$];
  logic        tog1[$];
  vec_t        vecs[NV];

  handshake_tx_fifo_if #(.DW(32), .DEPTH(4)) bus0 ();
  handshake_tx_fifo_if #(.DW(32), .DEPTH(4)) bus1 ();
  handshake_tx_fifo_if #(.DW(32), .DEPTH(4)) bus3 ();

  handshake_tx_fifo #(.DW(32), .DEPTH(4), .MODE(0), .SYNC_STAGES(2)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  handshake_tx_fifo #(.DW(32), .DEPTH(4), .MODE(1), .SYNC_STAGES(2)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );
  handshake_tx_fifo #(.DW(32), .DEPTH(4), .MODE(0), .SYNC_STAGES(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receiver model: ack mirrors req a few cycles later
  assign bus0.ack_i = resp_en0 ? hist0[2] : man_ack0;
  assign bus1.ack_i = hist1[2];
  assign bus3.ack_i = man_ack3;

  initial begin
    hist0 = '0; hist1 = '0; prev0 = 1'b0; prev1 = 1'b0;
    done_cnt0 = 0; done_cnt1 = 0;
  end

  always @(negedge clk) begin
    hist0 <= {hist0[1:0], bus0.req_o};
    hist1 <= {hist1[1:0], bus1.req_o};
    if (bus0.req_o && !prev0) cap0.push_back(bus0.req_data_o);
    if (bus1.req_o != prev1) begin
      cap1.push_back(bus1.req_data_o);
      tog1.push_back(bus1.req_o);
    end
    prev0 <= bus0.req_o;
    prev1 <= bus1.req_o;
    if (bus0.done_o) done_cnt0 <= done_cnt0 + 1;
    if (bus1.done_o) done_cnt1 <= done_cnt1 + 1;
  end

  function automatic vec_t mk(input logic r, input logic [31:0] d, input logic a,
                              input logic er, input logic [31:0] ed, input logic rdy,
                              input logic idl, input logic [2:0] lvl, input logic dn,
                              input logic ov);
    vec_t v;
    v.req = r; v.data = d; v.ack = a;
    v.exp_req = er; v.exp_data = ed; v.exp_ready = rdy; v.exp_idle = idl;
    v.exp_level = lvl; v.exp_done = dn; v.exp_ovf = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_push(input bit sel, input logic r, input logic [31:0] d);
    if (sel) begin bus3.req_i = r; bus3.req_data_i = d; end
    else begin bus0.req_i = r; bus0.req_data_i = d; end
  endtask

  task automatic set_ack(input bit sel, input logic a);
    if (sel) man_ack3 = a;
    else man_ack0 = a;
  endtask

  function automatic logic rd_req(input bit sel);
    return sel ? bus3.req_o : bus0.req_o;
  endfunction

  function automatic logic rd_done(input bit sel);
    return sel ? bus3.done_o : bus0.done_o;
  endfunction

  task automatic lat_test(input bit sel, output int up_lat, output int dn_lat);
    set_push(sel, 1'b1, 32'hA5A50000);
    @(negedge clk);
    set_push(sel, 1'b0, 32'h0);
    for (int i = 0; i < 20 && !rd_req(sel); i++) @(negedge clk);
    set_ack(sel, 1'b1);
    up_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!rd_req(sel)) begin up_lat = i; break; end
    end
    set_ack(sel, 1'b0);
    dn_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rd_done(sel)) begin dn_lat = i; break; end
    end
  endtask

  initial begin
    int   base_c;
    int   base_d;
    int   up0, dn0, up3, dn3;
    bit   hit;
    logic [2:0] fill_lvl[6];
    logic       fill_rdy[6];
    logic       fill_ovf[6];
    logic [31:0] sim_w[4];

    checks = 0; errors = 0;
    rst = 1'b1;
    bus0.req_i = 1'b0; bus0.req_data_i = '0; man_ack0 = 1'b0; resp_en0 = 1'b0;
    bus1.req_i = 1'b0; bus1.req_data_i = '0;
    bus3.req_i = 1'b0; bus3.req_data_i = '0; man_ack3 = 1'b0;

    // single four-phase transfer, then ack noise while idle
    vecs[0] = mk(1, DB, 0, 0, 32'h0, 1, 1, 0, 0, 0);
    vecs[1] = mk(0, 0,  0, 0, 32'h0, 1, 0, 1, 0, 0);
    for (int i = 2; i <= 4; i++)   vecs[i] = mk(0, 0, 0, 1, DB, 1, 0, 0, 0, 0);
    for (int i = 5; i <= 7; i++)   vecs[i] = mk(0, 0, 1, 1, DB, 1, 0, 0, 0, 0);
    for (int i = 8; i <= 10; i++)  vecs[i] = mk(0, 0, 1, 0, DB, 1, 0, 0, 0, 0);
    for (int i = 11; i <= 13; i++) vecs[i] = mk(0, 0, 0, 0, DB, 1, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, DB, 1, 1, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, DB, 1, 1, 0, 0, 0);
    for (int i = 16; i <= 17; i++) vecs[i] = mk(0, 0, 1, 0, DB, 1, 1, 0, 0, 0);
    for (int i = 18; i < NV; i++)  vecs[i] = mk(0, 0, 0, 0, DB, 1, 1, 0, 0, 0);

    fill_lvl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    fill_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    fill_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus0.req_i = vecs[i].req; bus0.req_data_i = vecs[i].data; man_ack0 = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_req", i),   bus0.req_o,      vecs[i].exp_req);
      chk($sformatf("v%0d_data", i),  bus0.req_data_o, vecs[i].exp_data);
      chk($sformatf("v%0d_ready", i), bus0.ready_o,    vecs[i].exp_ready);
      chk($sformatf("v%0d_idle", i),  bus0.idle_o,     vecs[i].exp_idle);
      chk($sformatf("v%0d_level", i), bus0.level_o,    vecs[i].exp_level);
      chk($sformatf("v%0d_done", i),  bus0.done_o,     vecs[i].exp_done);
      chk($sformatf("v%0d_ovf", i),   bus0.ovf_o,      vecs[i].exp_ovf);
      @(negedge clk);
    end

    // fill: first word launches at once, next four fill the FIFO, sixth overflows
    base_c = cap0.size(); base_d = done_cnt0;
    for (int i = 0; i < 6; i++) begin
      bus0.req_i = 1'b1; bus0.req_data_i = 32'h10000000 + i;
      #1;
      chk($sformatf("fill%0d_level", i), bus0.level_o, fill_lvl[i]);
      chk($sformatf("fill%0d_ready", i), bus0.ready_o, fill_rdy[i]);
      chk($sformatf("fill%0d_ovf", i),   bus0.ovf_o,   fill_ovf[i]);
      @(negedge clk);
    end
    bus0.req_i = 1'b0;
    #1;
    chk("fill_hold_level", bus0.level_o, 4);
    chk("fill_hold_ready", bus0.ready_o, 0);
    chk("fill_hold_ovf", bus0.ovf_o, 0);
    chk("fill_hold_req", bus0.req_o, 1);
    chk("fill_hold_data", bus0.req_data_o, 32'h10000000);
    resp_en0 = 1'b1;
    for (int i = 0; i < 400 && (done_cnt0 - base_d) < 5; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("fill_done_count", done_cnt0 - base_d, 5);
    chk("fill_cap_count", cap0.size() - base_c, 5);
    for (int k = 0; k < 5; k++)
      if (cap0.size() > base_c + k) chk($sformatf("fill_order%0d", k), cap0[base_c + k], 32'h10000000 + k);
    chk("fill_idle", bus0.idle_o, 1);

    // push during the launch cycle keeps the level unchanged
    resp_en0 = 1'b0;
    repeat (6) @(negedge clk);
    sim_w = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
    base_c = cap0.size(); base_d = done_cnt0;
    for (int i = 0; i < 3; i++) begin
      bus0.req_i = 1'b1; bus0.req_data_i = sim_w[i];
      @(negedge clk);
    end
    bus0.req_i = 1'b0;
    #1;
    chk("simul_pre_level", bus0.level_o, 2);
    resp_en0 = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (bus0.done_o) begin
        hit = 1'b1;
        chk("simul_launch_level", bus0.level_o, 2);
        chk("simul_launch_idle", bus0.idle_o, 0);
        bus0.req_i = 1'b1; bus0.req_data_i = sim_w[3];
        @(negedge clk);
        bus0.req_i = 1'b0;
        #1;
        chk("simul_post_level", bus0.level_o, 2);
        break;
      end
    end
    chk("simul_done_seen", hit, 1);
    for (int i = 0; i < 400 && (done_cnt0 - base_d) < 4; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("simul_done_count", done_cnt0 - base_d, 4);
    chk("simul_cap_count", cap0.size() - base_c, 4);
    for (int k = 0; k < 4; k++)
      if (cap0.size() > base_c + k) chk($sformatf("simul_order%0d", k), cap0[base_c + k], sim_w[k]);

    // two-phase toggle transfers
    base_c = cap1.size(); base_d = done_cnt1;
    for (int i = 1; i <= 3; i++) begin
      bus1.req_i = 1'b1; bus1.req_data_i = i;
      @(negedge clk);
    end
    bus1.req_i = 1'b0;
    for (int i = 0; i < 300 && (done_cnt1 - base_d) < 3; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("tog_done_count", done_cnt1 - base_d, 3);
    chk("tog_change_count", cap1.size() - base_c, 3);
    for (int k = 0; k < 3; k++)
      if (cap1.size() > base_c + k) begin
        chk($sformatf("tog_data%0d", k), cap1[base_c + k], k + 1);
        chk($sformatf("tog_phase%0d", k), tog1[base_c + k], (k % 2 == 0) ? 1 : 0);
      end
    chk("tog_idle", bus1.idle_o, 1);

    // synchroniser depth adds one cycle per phase
    resp_en0 = 1'b0; man_ack0 = 1'b0;
    repeat (6) @(negedge clk);
    lat_test(1'b0, up0, dn0);
    lat_test(1'b1, up3, dn3);
    chk("lat_ss2_ack_rise", up0, 3);
    chk("lat_ss2_ack_fall", dn0, 3);
    chk("lat_ss3_ack_rise", up3, 4);
    chk("lat_ss3_ack_fall", dn3, 4);

    // reset while waiting for ack release with two words queued
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus0.req_i = 1'b1; bus0.req_data_i = 32'h70 + i;
      @(negedge clk);
    end
    bus0.req_i = 1'b0;
    man_ack0 = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (!bus0.req_o) begin hit = 1'b1; break; end
    end
    chk("rst_reached_rel", hit, 1);
    chk("rst_pre_level", bus0.level_o, 2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req", bus0.req_o, 0);
    chk("rst_data", bus0.req_data_o, 0);
    chk("rst_ready", bus0.ready_o, 1);
    chk("rst_idle", bus0.idle_o, 1);
    chk("rst_level", bus0.level_o, 0);
    chk("rst_done", bus0.done_o, 0);
    chk("rst_ovf", bus0.ovf_o, 0);
    rst = 1'b0;
    base_d = done_cnt0;
    repeat (4) @(negedge clk);
    man_ack0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_done", done_cnt0 - base_d, 0);
    chk("rst_still_idle", bus0.idle_o, 1);
    base_c = cap0.size(); base_d = done_cnt0;
    resp_en0 = 1'b1;
    bus0.req_i = 1'b1; bus0.req_data_i = 32'hC0FFEE00;
    @(negedge clk);
    bus0.req_i = 1'b0;
    for (int i = 0; i < 100 && (done_cnt0 - base_d) < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("post_rst_done", done_cnt0 - base_d, 1);
    chk("post_rst_cap_count", cap0.size() - base_c, 1);
    if (cap0.size() > base_c) chk("post_rst_data", cap0[base_c], 32'hC0FFEE00);
    chk("post_rst_idle", bus0.idle_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
